// File: rtl/gap_fill_stream.sv
// Zero-run repair stage for a valid/ready sample stream: short runs of zero
// samples are replaced by the held previous value or by the neighbour average.
module gap_fill_stream #(
    parameter int DATA_W  = 64,
    parameter int MAX_GAP = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  fill_count,
    output logic              gap_overflow
);

    // Run counter must hold MAX_GAP+1 (the overflowing run length).
    localparam int               RUN_W   = $clog2(MAX_GAP + 2);
    localparam logic [RUN_W-1:0] GAP_MAX = RUN_W'(MAX_GAP);
    localparam logic [RUN_W-1:0] GAP_OVF = RUN_W'(MAX_GAP + 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [1:0]       MODE_BYPASS = 2'd0;
    localparam logic [1:0]       MODE_HOLD   = 2'd1;

    typedef enum logic [2:0] {
        S_PASS,
        S_COLLECT,
        S_FILL,
        S_FLUSH,
        S_RAW
    } state_t;

    state_t             state, state_nxt;
    logic               last_valid, last_valid_nxt;
    logic [DATA_W-1:0]  last_val, last_val_nxt;
    logic [DATA_W-1:0]  next_val, next_val_nxt;
    logic [RUN_W-1:0]   run_cnt, run_cnt_nxt;
    logic [RUN_W-1:0]   emit_cnt, emit_cnt_nxt;
    logic               run_hold, run_hold_nxt;
    logic               from_ovf, from_ovf_nxt;
    logic [DATA_W-1:0]  out_data_nxt;
    logic               out_valid_nxt;
    logic [CNT_W-1:0]   fill_count_nxt;
    logic               gap_overflow_nxt;

    logic               adv;
    logic               in_fire;
    logic               in_zero;
    logic [DATA_W:0]    avg_sum;
    logic [DATA_W-1:0]  fill_val;

    assign adv      = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign in_zero  = (in_data == '0);
    // One extra bit keeps the average of two large samples from wrapping.
    assign avg_sum  = {1'b0, last_val} + {1'b0, next_val};
    assign fill_val = run_hold ? last_val : avg_sum[DATA_W:1];

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_PASS, S_RAW: in_ready = adv;
            S_COLLECT:     in_ready = !flush;
            default:       in_ready = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt        = state;
        last_valid_nxt   = last_valid;
        last_val_nxt     = last_val;
        next_val_nxt     = next_val;
        run_cnt_nxt      = run_cnt;
        emit_cnt_nxt     = emit_cnt;
        run_hold_nxt     = run_hold;
        from_ovf_nxt     = from_ovf;
        out_data_nxt     = out_data;
        out_valid_nxt    = out_valid && !out_ready;
        fill_count_nxt   = fill_count;
        gap_overflow_nxt = 1'b0;

        case (state)
            S_PASS: begin
                if (in_fire) begin
                    if (!in_zero) begin
                        out_data_nxt   = in_data;
                        out_valid_nxt  = 1'b1;
                        last_val_nxt   = in_data;
                        last_valid_nxt = 1'b1;
                    end else if (mode == MODE_BYPASS || !last_valid) begin
                        out_data_nxt  = '0;
                        out_valid_nxt = 1'b1;
                    end else begin
                        run_hold_nxt = (mode == MODE_HOLD);
                        run_cnt_nxt  = RUN_ONE;
                        state_nxt    = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (flush) begin
                    from_ovf_nxt = 1'b0;
                    emit_cnt_nxt = '0;
                    state_nxt    = S_FLUSH;
                end else if (in_fire) begin
                    if (!in_zero) begin
                        next_val_nxt = in_data;
                        emit_cnt_nxt = '0;
                        state_nxt    = S_FILL;
                    end else if (run_cnt < GAP_MAX) begin
                        run_cnt_nxt = run_cnt + RUN_ONE;
                    end else begin
                        run_cnt_nxt      = GAP_OVF;
                        gap_overflow_nxt = 1'b1;
                        from_ovf_nxt     = 1'b1;
                        emit_cnt_nxt     = '0;
                        state_nxt        = S_FLUSH;
                    end
                end
            end

            S_FILL: begin
                if (adv) begin
                    out_valid_nxt = 1'b1;
                    if (emit_cnt == run_cnt) begin
                        out_data_nxt   = next_val;
                        last_val_nxt   = next_val;
                        fill_count_nxt = fill_count + CNT_W'(run_cnt);
                        state_nxt      = S_PASS;
                    end else begin
                        out_data_nxt = fill_val;
                        emit_cnt_nxt = emit_cnt + RUN_ONE;
                    end
                end
            end

            S_FLUSH: begin
                if (adv) begin
                    out_data_nxt  = '0;
                    out_valid_nxt = 1'b1;
                    if (emit_cnt == run_cnt - RUN_ONE) begin
                        // An overflowed run keeps passing zeros until data returns.
                        state_nxt = from_ovf ? S_RAW : S_PASS;
                    end else begin
                        emit_cnt_nxt = emit_cnt + RUN_ONE;
                    end
                end
            end

            S_RAW: begin
                if (in_fire) begin
                    out_data_nxt  = in_data;
                    out_valid_nxt = 1'b1;
                    if (!in_zero) begin
                        last_val_nxt   = in_data;
                        last_valid_nxt = 1'b1;
                        state_nxt      = S_PASS;
                    end
                end
            end

            default: state_nxt = S_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_PASS;
            last_valid   <= 1'b0;
            last_val     <= '0;
            next_val     <= '0;
            run_cnt      <= '0;
            emit_cnt     <= '0;
            run_hold     <= 1'b0;
            from_ovf     <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            fill_count   <= '0;
            gap_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, regardless of statement order.
            state        <= state_nxt;
            last_valid   <= last_valid_nxt;
            last_val     <= last_val_nxt;
            next_val     <= next_val_nxt;
            run_cnt      <= run_cnt_nxt;
            emit_cnt     <= emit_cnt_nxt;
            run_hold     <= run_hold_nxt;
            from_ovf     <= from_ovf_nxt;
            out_data     <= out_data_nxt;
            out_valid    <= out_valid_nxt;
            fill_count   <= fill_count_nxt;
            gap_overflow <= gap_overflow_nxt;
        end
    end

endmodule

// File: tb/tb_gap_fill_stream.sv
// Directed self-checking bench for gap_fill_stream: repair modes, overflow,
// wide-value averaging, output stalls, async reset and flush.
module tb_gap_fill_stream;

    localparam int DATA_W  = 64;
    localparam int MAX_GAP = 4;
    localparam int CNT_W   = 32;
    localparam logic [DATA_W-1:0] ONES = '1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        mode = 2'd2;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CNT_W-1:0]  fill_count;
    logic              gap_overflow;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] out_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                out_rd = 0;
    int                ovf_seen = 0;
    int                ovf_base;

    always #5 clk = ~clk;

    gap_fill_stream #(
        .DATA_W (DATA_W),
        .MAX_GAP(MAX_GAP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_count  (fill_count),
        .gap_overflow(gap_overflow)
    );

    // Output transfers and overflow pulses, observed mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (gap_overflow) ovf_seen++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample is accepted.
    task automatic send(input logic [DATA_W-1:0] d);
        int waited;
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Waits for exp_q.size() new outputs, idles a few cycles to catch extras,
    // then compares the captured sequence against exp_q.
    task automatic expect_outputs(input string tag);
        int waited;
        int got;
        waited = 0;
        while ((out_q.size() - out_rd) < exp_q.size() && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
        #1;
        got = out_q.size() - out_rd;
        check({tag, "_count"}, 64'(got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got) check($sformatf("%s[%0d]", tag, i), out_q[out_rd + i], exp_q[i]);
        end
        out_rd = out_q.size();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_fill_count", 64'(fill_count), 64'd0);
        check("rst_gap_overflow", 64'(gap_overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // AVG: 10,0,0,20 -> 10,15,15,20
        mode = 2'd2;
        send(64'd10); send(64'd0); send(64'd0); send(64'd20);
        exp_q = '{64'd10, 64'd15, 64'd15, 64'd20};
        expect_outputs("avg");
        check("avg_fill_count", 64'(fill_count), 64'd2);

        // HOLD: 7,0,9 -> 7,7,9 (fill_count accumulates to 3)
        mode = 2'd1;
        send(64'd7); send(64'd0); send(64'd9);
        exp_q = '{64'd7, 64'd7, 64'd9};
        expect_outputs("hold");
        check("hold_fill_count", 64'(fill_count), 64'd3);

        // Overflow: 5, five zeros, 8 -> passes through unrepaired
        mode = 2'd2;
        ovf_base = ovf_seen;
        send(64'd5);
        repeat (5) send(64'd0);
        send(64'd8);
        exp_q = '{64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd8};
        expect_outputs("ovf");
        check("ovf_pulses", 64'(ovf_seen - ovf_base), 64'd1);
        check("ovf_fill_count", 64'(fill_count), 64'd3);

        // Wide average must not wrap
        mode = 2'd3;
        send(ONES); send(64'd0); send(ONES);
        exp_q = '{ONES, ONES, ONES};
        expect_outputs("wide_avg");
        check("wide_fill_count", 64'(fill_count), 64'd4);

        // Same run in BYPASS: zero passes raw
        mode = 2'd0;
        send(ONES); send(64'd0); send(ONES);
        exp_q = '{ONES, 64'd0, ONES};
        expect_outputs("bypass");
        check("bypass_fill_count", 64'(fill_count), 64'd4);

        // Stall mid-FILL: output held, input blocked
        mode = 2'd2;
        send(64'd10); send(64'd0); send(64'd0); send(64'd20);
        @(posedge clk);
        #1;
        check("stall_first_data", out_data, 64'd15);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_data", out_data, 64'd15);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q = '{64'd10, 64'd15, 64'd15, 64'd20};
        expect_outputs("stall");
        check("stall_fill_count", 64'(fill_count), 64'd6);

        // Async reset mid-FILL
        send(64'd10); send(64'd0); send(64'd0); send(64'd20);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_fill_count", 64'(fill_count), 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        out_rd = out_q.size();

        // No prior non-zero: leading zeros pass raw
        send(64'd0); send(64'd0); send(64'd4);
        exp_q = '{64'd0, 64'd0, 64'd4};
        expect_outputs("lead_zero");
        check("lead_fill_count", 64'(fill_count), 64'd0);

        // Flush a pending run: 3,0,flush -> 3,0
        ovf_base = ovf_seen;
        send(64'd3); send(64'd0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q = '{64'd3, 64'd0};
        expect_outputs("flush");
        check("flush_fill_count", 64'(fill_count), 64'd0);
        check("flush_no_ovf", 64'(ovf_seen - ovf_base), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gap_fill_stream.md
Name: gap_fill_stream

Overview:
- Parametrised successor to the single-sample zero-replacement stage.
- Detects runs of up to MAX_GAP consecutive zero samples in a valid/ready stream.
- Replaces each zero in a run with either the held last non-zero value or the average of the bounding non-zero neighbours. Runs longer than MAX_GAP pass through unrepaired.
- Sits between the sample source and downstream consumers; full backpressure support.

Parameters:
- DATA_W, 64, sample width in bits.
- MAX_GAP, 4, longest zero run that is repaired (>=1).
- CNT_W, 32, width of the repaired-sample counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- mode  input  2  0=BYPASS, 1=HOLD, 2=AVG, 3=AVG.
- flush  input  1  force pending zero run out unrepaired.
- out_data  output  DATA_W  output sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- fill_count  output  CNT_W  total samples repaired; wraps modulo 2^CNT_W.
- gap_overflow  output  1  one-cycle pulse when a run exceeds MAX_GAP.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, fill_count=0, gap_overflow=0.
  - State=PASS, last_valid=0, last (L)=0, run_cnt=0.
- Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
- Output register advances when !out_valid|out_ready ("adv"). While out_valid=1 and out_ready=0, out_data is held stable.
- States PASS, COLLECT, FILL, FLUSH, RAW.
- PASS: in_ready=adv.
  - Non-zero input: emit it next cycle (latency 1); L<=input; last_valid<=1.
  - Zero input with mode=0 or last_valid=0: emit raw.
  - Zero input otherwise: latch mode, run_cnt<=1, go COLLECT; nothing is emitted.
- COLLECT: in_ready=!flush; no output produced.
  - Zero input with run_cnt<MAX_GAP: run_cnt++.
  - Zero input with run_cnt==MAX_GAP: run_cnt<=MAX_GAP+1; pulse gap_overflow; go FLUSH.
  - Non-zero input N: latch N; go FILL.
  - flush=1: go FLUSH with current run_cnt; no input accepted that cycle.
- FILL: in_ready=0.
  - Emit run_cnt fill samples, one per adv: HOLD uses L; AVG uses (L+N)>>1, with the sum formed at DATA_W+1 bits (no wrap).
  - Then emit N; L<=N; fill_count += run_cnt; go PASS.
- FLUSH: in_ready=0.
  - Emit run_cnt zeros raw; fill_count unchanged.
  - After overflow go RAW; after flush go PASS with last_valid unchanged.
- RAW: in_ready=adv.
  - Zeros pass raw.
  - First non-zero passes; L<=it; go PASS.
- Mode is sampled only on PASS→COLLECT; changes mid-run do not affect that run.
- flush is ignored outside COLLECT.
- gap_overflow is asserted exactly one cycle per overflowing run.
- Order is always preserved; no sample is dropped or duplicated under any out_ready pattern.

Test Plan:
- AVG, inputs 10,0,0,20, out_ready=1 → out 10,15,15,20; fill_count=2.
- HOLD, inputs 7,0,9 → out 7,7,9; fill_count=1.
- AVG, inputs 5, then 0 ×5, then 8 → out 5,0,0,0,0,0,8; gap_overflow pulses once; fill_count=0.
- AVG, L=N=all-ones (64'hFFFF_FFFF_FFFF_FFFF), one zero between → fill sample all-ones, no wrap. Same run in BYPASS → zero passes raw.
- AVG, inputs 10,0,0,20 with out_ready low 3 cycles mid-FILL → out_data stable while stalled; sequence still 10,15,15,20; in_ready=0 throughout FILL.
- Reset asserted mid-FILL → out_valid=0 immediately. After release, inputs 0,0,4 → out 0,0,4 (leading zeros raw). Separately, 3,0 then flush → out 3,0.
